// File: rtl/relax_osc_freq_meter_if.sv
// Control and readout bundle between the project top level and the relaxation
// oscillator frequency meter.
interface relax_osc_freq_meter_if;
  logic       ena;
  logic       start;
  logic       continuous;
  logic [2:0] gate_sel;
  logic [1:0] byte_sel;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  modport master (
    output ena, start, continuous, gate_sel, byte_sel,
    input  busy, done, data_out
  );

  modport slave (
    input  ena, start, continuous, gate_sel, byte_sel,
    output busy, done, data_out
  );
endinterface

// File: rtl/relax_osc_freq_meter.sv
// Sequences a relaxation oscillator (enable, settle, gated edge count) and
// presents the latched count and status byte-wise.
module relax_osc_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  osc_in,
  output logic                  osc_en,
  relax_osc_freq_meter_if.slave bus
);

  localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, LATCH} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3, edge_stb;
  logic [SET_W-1:0] settle_cnt;
  logic [14:0]      gate_cnt, gate_load;
  logic [2:0]       gate_reg;
  logic [CNT_W-1:0] edge_cnt, edge_nxt, result;
  logic             ovf_acc, ovf_nxt, overflow, valid, busy, done;
  logic             gate_entry, gate_last;
  logic [7:0]       data_out;

  // osc_in is asynchronous: two synchroniser flops plus a delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_stb  = s2 & ~s3;
  assign gate_load = 15'((16'd1 << ({1'b0, bus.gate_sel} + 4'd8)) - 16'd1);

  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_acc;
    if (edge_stb) begin
      if (edge_cnt == CNT_MAX) ovf_nxt  = 1'b1;
      else                     edge_nxt = edge_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = GATE;
      GATE:    if (gate_cnt == '0) state_nxt = LATCH;
      LATCH:   state_nxt = bus.continuous ? GATE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!bus.ena) state_nxt = IDLE;
  end

  assign gate_entry = (state_nxt == GATE) && (state != GATE);
  assign gate_last  = (state == GATE) && (state_nxt == LATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      osc_en <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      osc_en <= (state_nxt != IDLE);
      done   <= gate_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      gate_cnt   <= '0;
      gate_reg   <= '0;
      edge_cnt   <= '0;
      ovf_acc    <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == SETTLE) settle_cnt <= SETTLE_LOAD;
      else if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);

      if (gate_entry) begin
        gate_reg <= bus.gate_sel;
        gate_cnt <= gate_load;
        edge_cnt <= '0;
        ovf_acc  <= 1'b0;
      end else if (state == GATE) begin
        if (gate_cnt != '0) gate_cnt <= gate_cnt - 15'd1;
        edge_cnt <= edge_nxt;
        ovf_acc  <= ovf_nxt;
      end
    end
  end

  // The final gate cycle's edge is folded in so result is visible together with done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else if (gate_last) begin
      result   <= edge_nxt;
      overflow <= ovf_nxt;
      valid    <= 1'b1;
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (bus.byte_sel)
      2'd0:    data_out = result[7:0];
      2'd1:    data_out = 8'(result >> 8);
      2'd2:    data_out = {overflow, busy, valid, osc_en, 1'b0, gate_reg};
      default: data_out = 8'h00;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.data_out = data_out;

endmodule

// File: tb/tb_relax_osc_freq_meter.sv
// Directed bench for the oscillator frequency meter: single shot, start while
// busy, abort, continuous, saturation (CNT_W=10 instance) and mid-gate reset.
module tb_relax_osc_freq_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic osc_a = 1'b0;
  logic osc_b = 1'b0;
  logic osc_en_a, osc_en_b;
  int   osc_half = 40;
  int   total = 0;
  int   bad = 0;
  logic mon_on = 1'b0;
  logic osc_dropped = 1'b0;

  relax_osc_freq_meter_if bus ();
  relax_osc_freq_meter_if bus_sat ();

  relax_osc_freq_meter #(.CNT_W(16), .SETTLE_CYCLES(256)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_a),
    .osc_en (osc_en_a),
    .bus    (bus)
  );

  relax_osc_freq_meter #(.CNT_W(10), .SETTLE_CYCLES(256)) dut_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_b),
    .osc_en (osc_en_b),
    .bus    (bus_sat)
  );

  always #5 clk = ~clk;
  always #(osc_half) osc_a = ~osc_a;
  always @(negedge clk) osc_b = ~osc_b;
  always @(negedge clk) if (mon_on && !osc_en_a) osc_dropped = 1'b1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input logic [31:0] obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic ena, input logic start, input logic cont, input logic [2:0] gsel);
    bus.ena        = ena;
    bus.start      = start;
    bus.continuous = cont;
    bus.gate_sel   = gsel;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic readByte(input logic sat, input logic [1:0] sel, output logic [7:0] v);
    if (sat) begin
      bus_sat.byte_sel = sel;
      #1 v = bus_sat.data_out;
    end else begin
      bus.byte_sel = sel;
      #1 v = bus.data_out;
    end
  endtask

  task automatic readResult(output logic [15:0] r);
    logic [7:0] lo, hi;
    readByte(1'b0, 2'd0, lo);
    readByte(1'b0, 2'd1, hi);
    r = {hi, lo};
  endtask

  task automatic waitDone(input logic sat, input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      step(1);
      cycles++;
      if (sat ? bus_sat.done : bus.done) break;
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] r;
    int          c;
    logic        seen;

    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    bus.byte_sel         = 2'd0;
    bus_sat.ena          = 1'b0;
    bus_sat.start        = 1'b0;
    bus_sat.continuous   = 1'b0;
    bus_sat.gate_sel     = 3'd3;
    bus_sat.byte_sel     = 2'd0;
    step(3);
    rst_n = 1'b1;
    step(3);
    checkOutput("idle_busy", 32'(bus.busy), 0);

    // Single shot: period 8, gate 256 -> 32 edges, done 512 cycles after start
    $display("[TB] single shot");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    step(1);
    pulseStart();
    checkOutput("ss_osc_en", 32'(osc_en_a), 1);
    checkOutput("ss_busy", 32'(bus.busy), 1);
    waitDone(1'b0, 700, c);
    checkOutput("ss_done_cycle", 32'(c), 512);
    readResult(r);
    checkRange("ss_result", 32'(r), 31, 33);
    readByte(1'b0, 2'd1, b);
    checkOutput("ss_byte1", 32'(b), 0);
    step(1);
    checkOutput("ss_done_pulse", 32'(bus.done), 0);
    checkOutput("ss_busy_end", 32'(bus.busy), 0);
    readByte(1'b0, 2'd2, b);
    checkOutput("ss_status", 32'(b), 32'h20);

    // Start pulses during SETTLE and GATE must not restart anything
    $display("[TB] start while busy");
    step(2);
    pulseStart();
    step(10);
    pulseStart();
    step(289);
    pulseStart();
    checkOutput("sb_busy", 32'(bus.busy), 1);
    waitDone(1'b0, 400, c);
    checkOutput("sb_done_cycle", 32'(c), 211);
    readResult(r);
    checkRange("sb_result", 32'(r), 31, 33);
    step(2);

    // Abort halfway through the gate: no done, previous result retained
    $display("[TB] abort");
    pulseStart();
    step(384);
    bus.ena = 1'b0;
    step(1);
    checkOutput("ab_busy", 32'(bus.busy), 0);
    checkOutput("ab_osc_en", 32'(osc_en_a), 0);
    seen = bus.done;
    for (int i = 0; i < 300; i++) begin
      step(1);
      seen |= bus.done;
    end
    checkOutput("ab_no_done", 32'(seen), 0);
    readResult(r);
    checkRange("ab_result_held", 32'(r), 31, 33);
    readByte(1'b0, 2'd2, b);
    checkOutput("ab_status", 32'(b), 32'h20);

    // Continuous: period 16, gate 512 -> 32 edges, done every 513 cycles
    $display("[TB] continuous");
    osc_half = 80;
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd1);
    step(2);
    pulseStart();
    mon_on = 1'b1;
    waitDone(1'b0, 900, c);
    checkOutput("ct_done1_cycle", 32'(c), 768);
    readResult(r);
    checkRange("ct_result1", 32'(r), 31, 33);
    waitDone(1'b0, 600, c);
    checkOutput("ct_done2_cycle", 32'(c), 513);
    readResult(r);
    checkRange("ct_result2", 32'(r), 31, 33);
    step(1);
    bus.continuous = 1'b0;
    waitDone(1'b0, 600, c);
    checkOutput("ct_done3_cycle", 32'(c), 512);
    mon_on = 1'b0;
    checkOutput("ct_osc_never_dropped", 32'(osc_dropped), 0);
    step(1);
    checkOutput("ct_busy_end", 32'(bus.busy), 0);
    checkOutput("ct_osc_en_end", 32'(osc_en_a), 0);

    // Saturation: CNT_W=10, edge every 2 cycles over 2048 -> pinned at 1023
    $display("[TB] saturation");
    bus_sat.ena = 1'b1;
    bus_sat.start = 1'b1;
    step(1);
    bus_sat.start = 1'b0;
    waitDone(1'b1, 2500, c);
    checkOutput("sat_done_cycle", 32'(c), 2304);
    readByte(1'b1, 2'd0, b);
    checkOutput("sat_byte0", 32'(b), 32'hFF);
    readByte(1'b1, 2'd1, b);
    checkOutput("sat_byte1", 32'(b), 32'h03);
    readByte(1'b1, 2'd2, b);
    checkOutput("sat_status_latch", 32'(b), 32'hF3);
    step(1);
    readByte(1'b1, 2'd2, b);
    checkOutput("sat_status_idle", 32'(b), 32'hA3);

    // Reset asserted mid-gate clears outputs immediately
    $display("[TB] reset mid-gate");
    osc_half = 40;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    step(1);
    pulseStart();
    step(300);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_osc_en", 32'(osc_en_a), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    for (int s = 0; s < 4; s++) begin
      readByte(1'b0, 2'(s), b);
      checkOutput($sformatf("rst_byte%0d", s), 32'(b), 0);
    end
    step(2);
    rst_n = 1'b1;
    step(5);
    checkOutput("rst_idle_busy", 32'(bus.busy), 0);
    checkOutput("rst_idle_osc_en", 32'(osc_en_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
